// File: rtl/adpcm_code_unpacker_if.sv
// Serial ADPCM bitstream in, right-justified codeword out through a valid/ready stage.
interface adpcm_code_unpacker_if;
   logic [1:0] rate;
   logic       sdi;
   logic       svalid;
   logic       sync;
   logic       clr;
   logic [4:0] i;
   logic [1:0] irate;
   logic       ivalid;
   logic       iready;
   logic       syncerr;
   logic       ovf;

   modport master (
      output rate, sdi, svalid, sync, clr, iready,
      input  i, irate, ivalid, syncerr, ovf
   );

   modport slave (
      input  rate, sdi, svalid, sync, clr, iready,
      output i, irate, ivalid, syncerr, ovf
   );
endinterface

// File: rtl/adpcm_code_unpacker.sv
// Frames serial ADPCM codewords by SYNC, sizes them by rate (5/4/3/2 bits) and
// presents each one right-justified through a one-entry valid/ready output.
module adpcm_code_unpacker (
   input logic                   clk,
   input logic                   resetn,
   adpcm_code_unpacker_if.slave  bus
);
   typedef enum logic {HUNT, SHIFT} state_t;

   state_t     state;
   logic [4:0] sr;
   logic [2:0] cnt;
   logic [1:0] lrate;
   logic [4:0] sr_shift;
   logic       out_free;

   // Bits still expected after the SYNC bit itself.
   function automatic logic [2:0] width_m1(input logic [1:0] r);
      case (r)
         2'b00:   width_m1 = 3'd4;
         2'b01:   width_m1 = 3'd3;
         2'b10:   width_m1 = 3'd2;
         default: width_m1 = 3'd1;
      endcase
   endfunction

   // Upper bits of sr are zero from the SYNC load, so the word is already right-justified.
   assign sr_shift = {sr[3:0], bus.sdi};
   assign out_free = !bus.ivalid || bus.iready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= HUNT;
         sr          <= '0;
         cnt         <= '0;
         lrate       <= '0;
         bus.i       <= '0;
         bus.irate   <= '0;
         bus.ivalid  <= 1'b0;
         bus.syncerr <= 1'b0;
         bus.ovf     <= 1'b0;
      end else begin
         bus.syncerr <= 1'b0;
         if (bus.clr)
            bus.ovf <= 1'b0;
         if (bus.ivalid && bus.iready)
            bus.ivalid <= 1'b0;

         if (bus.svalid) begin
            if (bus.sync) begin
               if (state == SHIFT)
                  bus.syncerr <= 1'b1;
               sr    <= {4'b0000, bus.sdi};
               lrate <= bus.rate;
               cnt   <= width_m1(bus.rate);
               state <= SHIFT;
            end else if (state == SHIFT) begin
               sr  <= sr_shift;
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state <= HUNT;
                  // A completion that finds the output still occupied is lost; set beats clr.
                  if (out_free) begin
                     bus.i      <= sr_shift;
                     bus.irate  <= lrate;
                     bus.ivalid <= 1'b1;
                  end else begin
                     bus.ovf <= 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_adpcm_code_unpacker.sv
// Directed bench for adpcm_code_unpacker: stimulus pushes expected words, a monitor pops on each transfer.
module tb_adpcm_code_unpacker;
   logic clk;
   logic resetn;
   int   total = 0;
   int   bad = 0;
   int   syncerr_pulses = 0;
   logic [6:0] expq[$];

   adpcm_code_unpacker_if u_if ();

   adpcm_code_unpacker dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every accepted output must match the oldest expected word.
   always @(negedge clk) begin
      if (resetn && u_if.syncerr)
         syncerr_pulses++;
      if (resetn && u_if.ivalid && u_if.iready) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got i=%b irate=%b with nothing expected at %0t",
                     u_if.i, u_if.irate, $time);
         end else begin
            logic [6:0] e;
            e = expq.pop_front();
            chk("word_i", int'(u_if.i), int'(e[4:0]));
            chk("word_irate", int'(u_if.irate), int'(e[6:5]));
         end
      end
   end

   task automatic drive(input logic v, input logic y, input logic d, input logic [1:0] r);
      u_if.svalid = v;
      u_if.sync   = y;
      u_if.sdi    = d;
      u_if.rate   = r;
      @(posedge clk);
      #1;
      u_if.svalid = 1'b0;
      u_if.sync   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         drive(1'b0, 1'b0, 1'b0, u_if.rate);
   endtask

   task automatic word(input logic [1:0] r, input logic [4:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--)
         drive(1'b1, k == n - 1, bits[k], r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      resetn      = 1'b0;
      u_if.rate   = 2'b00;
      u_if.sdi    = 1'b0;
      u_if.svalid = 1'b0;
      u_if.sync   = 1'b0;
      u_if.clr    = 1'b0;
      u_if.iready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_i", int'(u_if.i), 0);
      chk("rst_irate", int'(u_if.irate), 0);
      chk("rst_ivalid", int'(u_if.ivalid), 0);
      chk("rst_syncerr", int'(u_if.syncerr), 0);
      chk("rst_ovf", int'(u_if.ovf), 0);
      resetn = 1'b1;
      idle(1);

      // Held output plus a partial 40k word, then asynchronous reset mid-word.
      word(2'b11, 5'b00011, 2);
      chk("held_before_reset", int'(u_if.ivalid), 1);
      drive(1'b1, 1'b1, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      resetn = 1'b0;
      #1;
      chk("async_rst_ivalid", int'(u_if.ivalid), 0);
      chk("async_rst_i", int'(u_if.i), 0);
      chk("async_rst_irate", int'(u_if.irate), 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      chk("hunt_ignores_bits", int'(u_if.ivalid), 0);
      u_if.iready = 1'b1;

      // Four rates, back to back.
      expq.push_back({2'b00, 5'b10110});
      expq.push_back({2'b01, 5'b01110});
      expq.push_back({2'b10, 5'b00101});
      expq.push_back({2'b11, 5'b00010});
      drive(1'b1, 1'b1, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      chk("r40_not_yet", int'(u_if.ivalid), 0);
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      chk("r40_latency", int'(u_if.ivalid), 1);
      chk("r40_i", int'(u_if.i), 5'b10110);
      word(2'b01, 5'b01110, 4);
      word(2'b10, 5'b00101, 3);
      word(2'b11, 5'b00010, 2);
      chk("r16_irate", int'(u_if.irate), 2'b11);
      idle(2);

      // Mid-word rate change with gaps: still a 4-bit word tagged 32k.
      expq.push_back({2'b01, 5'b01011});
      drive(1'b1, 1'b1, 1'b1, 2'b01);
      idle(2);
      drive(1'b1, 1'b0, 1'b0, 2'b11);
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      chk("rate_change_no_early", int'(u_if.ivalid), 0);
      idle(1);
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      chk("rate_change_done", int'(u_if.ivalid), 1);
      chk("rate_change_irate", int'(u_if.irate), 2'b01);
      idle(2);

      // Early SYNC after 3 bits of a 40k word.
      expq.push_back({2'b00, 5'b01101});
      drive(1'b1, 1'b1, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      chk("syncerr_idle", int'(u_if.syncerr), 0);
      drive(1'b1, 1'b1, 1'b0, 2'b00);
      chk("syncerr_pulse", int'(u_if.syncerr), 1);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      chk("syncerr_one_cycle", int'(u_if.syncerr), 0);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 1'b1, 2'b00);
      chk("early_sync_word", int'(u_if.i), 5'b01101);
      idle(2);

      // Backpressure: second 16k word is dropped.
      u_if.iready = 1'b0;
      expq.push_back({2'b11, 5'b00011});
      word(2'b11, 5'b00011, 2);
      chk("bp_no_ovf_yet", int'(u_if.ovf), 0);
      word(2'b11, 5'b00001, 2);
      chk("bp_ovf", int'(u_if.ovf), 1);
      chk("bp_hold_i", int'(u_if.i), 5'b00011);
      chk("bp_hold_valid", int'(u_if.ivalid), 1);
      u_if.iready = 1'b1;
      idle(1);
      chk("bp_drained", int'(u_if.ivalid), 0);
      chk("ovf_sticky", int'(u_if.ovf), 1);
      u_if.clr = 1'b1;
      idle(1);
      u_if.clr = 1'b0;
      chk("ovf_clr", int'(u_if.ovf), 0);

      // Overflow set and clr in the same cycle: set wins.
      u_if.iready = 1'b0;
      expq.push_back({2'b11, 5'b00010});
      word(2'b11, 5'b00010, 2);
      drive(1'b1, 1'b1, 1'b1, 2'b11);
      u_if.clr = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      u_if.clr = 1'b0;
      chk("ovf_set_wins", int'(u_if.ovf), 1);
      u_if.iready = 1'b1;
      idle(1);
      u_if.clr = 1'b1;
      idle(1);
      u_if.clr = 1'b0;
      chk("ovf_clr2", int'(u_if.ovf), 0);

      // Transfer and completion on the same edge.
      u_if.iready = 1'b0;
      expq.push_back({2'b11, 5'b00001});
      expq.push_back({2'b10, 5'b00110});
      word(2'b11, 5'b00001, 2);
      drive(1'b1, 1'b1, 1'b1, 2'b10);
      drive(1'b1, 1'b0, 1'b1, 2'b10);
      u_if.iready = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'b10);
      chk("simul_valid", int'(u_if.ivalid), 1);
      chk("simul_i", int'(u_if.i), 5'b00110);
      chk("simul_irate", int'(u_if.irate), 2'b10);
      chk("simul_no_ovf", int'(u_if.ovf), 0);
      idle(3);

      chk("queue_drained", expq.size(), 0);
      chk("syncerr_count", syncerr_pulses, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
